// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: slot tags,
// control FSM states and forwarding-source encodings.
package pipe_pkg;

    // Tags carry register addresses zero-extended to this width so one struct
    // serves every register-file size up to 2**TAG_RA_W entries.
    localparam int TAG_RA_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_RA_W-1:0] rd;
        logic                wen;
        logic                is_load;
        logic                is_halt;
    } tag_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    function automatic logic tag_hit(input tag_t t, input logic [TAG_RA_W-1:0] src);
        return t.valid && t.wen && (t.rd == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bundle between decoder/register file/datapath and the hazard unit.
// start/enable act as the request/permission pair: the unit moves to RUN only
// on a cycle where both are high, and leaves RUN on the first cycle enable is low.
interface pipe_hazard_unit_if #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
);
    import pipe_pkg::*;

    logic              start;
    logic              enable;
    logic [RA_W-1:0]   id_rs1;
    logic [RA_W-1:0]   id_rs2;
    logic              id_rs1_use;
    logic              id_rs2_use;
    logic [RA_W-1:0]   id_rd;
    logic              id_wen;
    logic              id_is_load;
    logic              id_is_branch;
    logic              id_is_halt;
    logic [DATA_W-1:0] rf_rs1_data;
    logic [DATA_W-1:0] rf_rs2_data;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] mem_load_data;
    logic [DATA_W-1:0] wb_result;

    logic              running;
    logic              stall_if;
    logic              inject_bubble;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic              halted;
    state_t            dbg_state;
    logic [1:0]        dbg_br_cnt;

    modport master (
        output start, enable, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_wen,
               id_is_load, id_is_branch, id_is_halt, rf_rs1_data, rf_rs2_data,
               ex_result, mem_result, mem_load_data, wb_result,
        input  running, stall_if, inject_bubble, opa, opb, fwd_sel_a, fwd_sel_b,
               halted, dbg_state, dbg_br_cnt
    );

    modport slave (
        input  start, enable, id_rs1, id_rs2, id_rs1_use, id_rs2_use, id_rd, id_wen,
               id_is_load, id_is_branch, id_is_halt, rf_rs1_data, rf_rs2_data,
               ex_result, mem_result, mem_load_data, wb_result,
        output running, stall_if, inject_bubble, opa, opb, fwd_sel_a, fwd_sel_b,
               halted, dbg_state, dbg_br_cnt
    );

endinterface

// File: rtl/pipe_fwd_mux.sv
// Per-operand forwarding select: youngest matching in-flight writer wins,
// falling back to register-file data.
module pipe_fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
) (
    input  logic              i_use,
    input  logic [RA_W-1:0]   i_src,
    input  tag_t              i_ex_tag,
    input  tag_t              i_mem_tag,
    input  tag_t              i_wb_tag,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic [DATA_W-1:0] i_ex_result,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic [DATA_W-1:0] i_mem_load_data,
    input  logic [DATA_W-1:0] i_wb_result,
    output logic [1:0]        o_sel,
    output logic [DATA_W-1:0] o_data
);

    logic [TAG_RA_W-1:0] w_src;
    logic                w_unused;

    assign w_src    = TAG_RA_W'(i_src);
    assign w_unused = &{1'b0, i_ex_tag.is_halt, i_mem_tag.is_halt, i_wb_tag.is_halt,
                        i_wb_tag.is_load};

    // A load still in EX has no data yet; the load-use stall covers that case,
    // so it is skipped here and older writers are considered instead.
    always_comb begin
        o_sel  = FWD_RF;
        o_data = i_rf_data;
        if (i_use) begin
            if (tag_hit(i_ex_tag, w_src) && !i_ex_tag.is_load) begin
                o_sel  = FWD_EX;
                o_data = i_ex_result;
            end else if (tag_hit(i_mem_tag, w_src)) begin
                o_sel  = FWD_MEM;
                o_data = i_mem_tag.is_load ? i_mem_load_data : i_mem_result;
            end else if (tag_hit(i_wb_tag, w_src)) begin
                o_sel  = FWD_WB;
                o_data = i_wb_result;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage in-order core: tag
// pipeline EX/MEM/WB, load-use and branch bubbles, run/idle/halt control.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int RA_W       = 3,
    parameter int BR_BUBBLES = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    pipe_hazard_unit_if.slave  io_hz
);

    localparam logic [1:0] BR_LOAD = 2'(BR_BUBBLES);

    state_t              r_state;
    state_t              w_state_nxt;
    tag_t                r_ex;
    tag_t                r_mem;
    tag_t                r_wb;
    tag_t                w_id_tag;
    logic [1:0]          r_br_cnt;
    logic                w_running;
    logic                w_cnt_busy;
    logic                w_load_use;
    logic                w_br_accept;
    logic                w_inject;
    logic [TAG_RA_W-1:0] w_rs1;
    logic [TAG_RA_W-1:0] w_rs2;

    assign w_running  = (r_state == ST_RUN);
    assign w_cnt_busy = (r_br_cnt != 2'd0);
    assign w_rs1      = TAG_RA_W'(io_hz.id_rs1);
    assign w_rs2      = TAG_RA_W'(io_hz.id_rs2);

    // While branch bubbles drain, the ID slot holds a wrong-path instruction
    // and must not raise a load-use stall or start another branch.
    assign w_load_use = !w_cnt_busy && r_ex.valid && r_ex.wen && r_ex.is_load &&
                        ((io_hz.id_rs1_use && (r_ex.rd == w_rs1)) ||
                         (io_hz.id_rs2_use && (r_ex.rd == w_rs2)));
    assign w_br_accept = w_running && !w_cnt_busy && !w_load_use && io_hz.id_is_branch;
    assign w_inject    = w_running && (w_load_use || w_cnt_busy);

    always_comb begin
        w_id_tag         = '0;
        w_id_tag.valid   = 1'b1;
        w_id_tag.rd      = TAG_RA_W'(io_hz.id_rd);
        w_id_tag.wen     = io_hz.id_wen;
        w_id_tag.is_load = io_hz.id_is_load;
        w_id_tag.is_halt = io_hz.id_is_halt;
    end

    // The halt is caught as it leaves MEM so HALT coincides with it reaching WB.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (io_hz.start && io_hz.enable) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!io_hz.enable)                   w_state_nxt = ST_IDLE;
                else if (r_mem.valid && r_mem.is_halt) w_state_nxt = ST_HALT;
            end
            ST_HALT: if (!io_hz.start) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_ex     <= '0;
            r_mem    <= '0;
            r_wb     <= '0;
            r_br_cnt <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_running) begin
                r_wb  <= r_mem;
                r_mem <= r_ex;
                r_ex  <= w_inject ? '0 : w_id_tag;
                if (w_cnt_busy)       r_br_cnt <= r_br_cnt - 2'd1;
                else if (w_br_accept) r_br_cnt <= BR_LOAD;
            end
        end
    end

    assign io_hz.running       = w_running;
    assign io_hz.halted        = (r_state == ST_HALT);
    assign io_hz.stall_if      = !w_running || w_load_use || w_cnt_busy;
    assign io_hz.inject_bubble = w_inject;
    assign io_hz.dbg_state     = r_state;
    assign io_hz.dbg_br_cnt    = r_br_cnt;

    pipe_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
        .i_use           (io_hz.id_rs1_use),
        .i_src           (io_hz.id_rs1),
        .i_ex_tag        (r_ex),
        .i_mem_tag       (r_mem),
        .i_wb_tag        (r_wb),
        .i_rf_data       (io_hz.rf_rs1_data),
        .i_ex_result     (io_hz.ex_result),
        .i_mem_result    (io_hz.mem_result),
        .i_mem_load_data (io_hz.mem_load_data),
        .i_wb_result     (io_hz.wb_result),
        .o_sel           (io_hz.fwd_sel_a),
        .o_data          (io_hz.opa)
    );

    pipe_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
        .i_use           (io_hz.id_rs2_use),
        .i_src           (io_hz.id_rs2),
        .i_ex_tag        (r_ex),
        .i_mem_tag       (r_mem),
        .i_wb_tag        (r_wb),
        .i_rf_data       (io_hz.rf_rs2_data),
        .i_ex_result     (io_hz.ex_result),
        .i_mem_result    (io_hz.mem_result),
        .i_mem_load_data (io_hz.mem_load_data),
        .i_wb_result     (io_hz.wb_result),
        .o_sel           (io_hz.fwd_sel_b),
        .o_data          (io_hz.opb)
    );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: two instances (2 and 3 branch bubbles) share one
// stimulus stream; a queue-based scoreboard checks them against an in-bench model.
module tb_pipe_hazard_unit;
    import pipe_pkg::*;

    localparam int DATA_W = 16;
    localparam int RA_W   = 3;
    localparam int NDUT   = 2;
    localparam int EW     = 41;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    // ---------------- clock / reset / shared stimulus ----------------
    logic clk = 1'b0;
    logic rst;
    logic start, enable, u1, u2, wen, ld, br, hlt;
    logic [RA_W-1:0]   rs1, rs2, rd;
    logic [DATA_W-1:0] rf1, rf2, exr, memr, meml, wbr;

    logic              o_run[NDUT];
    logic              o_halt[NDUT];
    logic              o_stall[NDUT];
    logic              o_inj[NDUT];
    logic [1:0]        o_sa[NDUT];
    logic [1:0]        o_sb[NDUT];
    logic [DATA_W-1:0] o_opa[NDUT];
    logic [DATA_W-1:0] o_opb[NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        pipe_hazard_unit_if #(.DATA_W(DATA_W), .RA_W(RA_W)) hz ();
        assign hz.start         = start;
        assign hz.enable        = enable;
        assign hz.id_rs1        = rs1;
        assign hz.id_rs2        = rs2;
        assign hz.id_rs1_use    = u1;
        assign hz.id_rs2_use    = u2;
        assign hz.id_rd         = rd;
        assign hz.id_wen        = wen;
        assign hz.id_is_load    = ld;
        assign hz.id_is_branch  = br;
        assign hz.id_is_halt    = hlt;
        assign hz.rf_rs1_data   = rf1;
        assign hz.rf_rs2_data   = rf2;
        assign hz.ex_result     = exr;
        assign hz.mem_result    = memr;
        assign hz.mem_load_data = meml;
        assign hz.wb_result     = wbr;
        assign o_run[g]   = hz.running;
        assign o_halt[g]  = hz.halted;
        assign o_stall[g] = hz.stall_if;
        assign o_inj[g]   = hz.inject_bubble;
        assign o_sa[g]    = hz.fwd_sel_a;
        assign o_sb[g]    = hz.fwd_sel_b;
        assign o_opa[g]   = hz.opa;
        assign o_opb[g]   = hz.opb;

        pipe_hazard_unit #(.DATA_W(DATA_W), .RA_W(RA_W), .BR_BUBBLES(g + 2)) u_dut (
            .i_clock (clk),
            .i_reset (rst),
            .io_hz   (hz)
        );
    end

    // ---------------- reference model ----------------
    // In-flight instructions, youngest first: [0] executing, [1] in memory, [2] writing back.
    typedef struct {
        bit v;
        int rd;
        bit wen;
        bit ld;
        bit hlt;
    } mtag_t;

    mtag_t m_pipe[NDUT][3];
    int    m_bub[NDUT];
    int    m_st[NDUT];

    function automatic bit m_writes(int d, int k, int src);
        return m_pipe[d][k].v && m_pipe[d][k].wen && (m_pipe[d][k].rd == src);
    endfunction

    function automatic bit m_load_use(int d);
        if (m_bub[d] != 0) return 1'b0;
        if (!(m_pipe[d][0].v && m_pipe[d][0].wen && m_pipe[d][0].ld)) return 1'b0;
        return (u1 && m_pipe[d][0].rd == int'(rs1)) || (u2 && m_pipe[d][0].rd == int'(rs2));
    endfunction

    task automatic m_fwd(input int d, input bit use_src, input int src, input logic [DATA_W-1:0] rfd,
                         output logic [1:0] sel, output logic [DATA_W-1:0] val);
        sel = 2'd0;
        val = rfd;
        if (!use_src) return;
        for (int k = 0; k < 3; k++) begin
            if (m_writes(d, k, src) && !(k == 0 && m_pipe[d][0].ld)) begin
                sel = 2'(k + 1);
                if (k == 0)      val = exr;
                else if (k == 1) val = m_pipe[d][1].ld ? meml : memr;
                else             val = wbr;
                return;
            end
        end
    endtask

    task automatic m_expect(input int d, output logic [EW-1:0] e);
        bit run, lu, inj, stall;
        logic [1:0] sa, sb;
        logic [DATA_W-1:0] va, vb;
        run   = (m_st[d] == M_RUN);
        lu    = m_load_use(d);
        inj   = run && (lu || m_bub[d] != 0);
        stall = !run || lu || m_bub[d] != 0;
        m_fwd(d, u1, int'(rs1), rf1, sa, va);
        m_fwd(d, u2, int'(rs2), rf2, sb, vb);
        e = {run, (m_st[d] == M_HALT), stall, inj, sa, sb, va, vb, !(lu || m_bub[d] != 0)};
    endtask

    task automatic m_step(input int d);
        bit run, lu, inj;
        int nst;
        if (rst) begin
            for (int k = 0; k < 3; k++) m_pipe[d][k] = '{0, 0, 0, 0, 0};
            m_bub[d] = 0;
            m_st[d]  = M_IDLE;
            return;
        end
        run = (m_st[d] == M_RUN);
        lu  = m_load_use(d);
        inj = run && (lu || m_bub[d] != 0);
        nst = m_st[d];
        case (m_st[d])
            M_IDLE: if (start && enable) nst = M_RUN;
            M_RUN: begin
                if (!enable) nst = M_IDLE;
                else if (m_pipe[d][1].v && m_pipe[d][1].hlt) nst = M_HALT;
            end
            default: if (!start) nst = M_IDLE;
        endcase
        if (run) begin
            m_pipe[d][2] = m_pipe[d][1];
            m_pipe[d][1] = m_pipe[d][0];
            if (inj) m_pipe[d][0] = '{0, 0, 0, 0, 0};
            else     m_pipe[d][0] = '{1, int'(rd), wen, ld, hlt};
            if (m_bub[d] > 0)  m_bub[d] = m_bub[d] - 1;
            else if (br && !lu) m_bub[d] = d + 2;
        end
        m_st[d] = nst;
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d (bubbles=%0d) t=%0t: got %0h, expected %0h",
                     name, d, d + 2, $time, act, exp);
        end
    endtask

    initial begin : monitor
        logic [EW-1:0] e;
        bit have;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                have = 1'b0;
                if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
                if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
                if (have) begin
                    check("running",       d, 32'(o_run[d]),   32'(e[40]));
                    check("halted",        d, 32'(o_halt[d]),  32'(e[39]));
                    check("stall_if",      d, 32'(o_stall[d]), 32'(e[38]));
                    check("inject_bubble", d, 32'(o_inj[d]),   32'(e[37]));
                    if (e[0]) begin
                        check("fwd_sel_a", d, 32'(o_sa[d]),  32'(e[36:35]));
                        check("fwd_sel_b", d, 32'(o_sb[d]),  32'(e[34:33]));
                        check("opa",       d, 32'(o_opa[d]), 32'(e[32:17]));
                        check("opb",       d, 32'(o_opb[d]), 32'(e[16:1]));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        logic [EW-1:0] e;
        for (int d = 0; d < NDUT; d++) begin
            m_expect(d, e);
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) m_step(d);
        #1;
    endtask

    task automatic id_set(input int r1, input bit a, input int r2, input bit b, input int dst,
                          input bit w, input bit l, input bit bb, input bit h);
        rs1 = RA_W'(r1); u1 = a; rs2 = RA_W'(r2); u2 = b; rd = RA_W'(dst);
        wen = w; ld = l; br = bb; hlt = h;
    endtask

    task automatic id_nop();
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_data();
        rf1 = DATA_W'($urandom); rf2 = DATA_W'($urandom); exr = DATA_W'($urandom);
        memr = DATA_W'($urandom); meml = DATA_W'($urandom); wbr = DATA_W'($urandom);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 3; k++) m_pipe[d][k] = '{0, 0, 0, 0, 0};
            m_bub[d] = 0;
            m_st[d]  = M_IDLE;
        end
        rst = 1'b1; start = 1'b0; enable = 1'b0;
        id_nop();
        rand_data();
        @(posedge clk);
        #1;
        cyc();
        rand_data(); id_set(2, 1, 6, 1, 0, 0, 0, 0, 0); cyc();

        // start/enable -> RUN
        rst = 1'b0; start = 1'b1; enable = 1'b1; id_nop(); cyc();
        start = 1'b0;

        // EX forward of r1
        rand_data(); id_set(0, 0, 0, 0, 1, 1, 0, 0, 0); cyc();
        rand_data(); exr = 16'h1234; id_set(1, 1, 0, 0, 2, 1, 0, 0, 0); cyc();

        // load-use on r3, then load data forwarded from MEM
        rand_data(); id_set(0, 0, 0, 0, 3, 1, 1, 0, 0); cyc();
        rand_data(); id_set(0, 0, 3, 1, 4, 1, 0, 0, 0); cyc();
        rand_data(); meml = 16'hBEEF; cyc();

        // r5 in MEM and WB: MEM copy wins
        rand_data(); id_set(0, 0, 0, 0, 5, 1, 0, 0, 0); cyc();
        cyc();
        rand_data(); id_nop(); cyc();
        rand_data(); memr = 16'h0001; wbr = 16'h0002; id_set(5, 1, 0, 0, 6, 1, 0, 0, 0); cyc();

        // branch bubbles
        rand_data(); id_set(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
        id_nop();
        repeat (4) begin rand_data(); cyc(); end

        // reset during a branch bubble, then restart
        id_set(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
        id_nop(); cyc();
        rst = 1'b1; cyc();
        rst = 1'b0; start = 1'b1; cyc();
        start = 1'b0; cyc();

        // enable drop mid-branch freezes the bubble count
        id_set(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
        id_nop(); cyc();
        enable = 1'b0; cyc(); cyc();
        enable = 1'b1; start = 1'b1; cyc();
        start = 1'b0;
        repeat (4) cyc();

        // halt reaches HALT three cycles after leaving ID, then back to IDLE
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
        id_nop();
        repeat (5) cyc();
        start = 1'b1; cyc();
        start = 1'b0;

        // randomized traffic
        repeat (3000) begin
            rst    = ($urandom_range(0, 99) == 0);
            start  = 1'($urandom_range(0, 1));
            enable = ($urandom_range(0, 9) != 0);
            rand_data();
            id_set($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
                   ($urandom_range(0, 39) == 0));
            cyc();
        end

        for (int i = 0; i < 5 && (exp_q0.size() + exp_q1.size()) != 0; i++) @(posedge clk);
        check("scoreboard_drain", 0, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
